sha256_msg_padder: RTL and testbench
====================================

Name: sha256_msg_padder

Overview:
- Streaming SHA-256 pre-processor between the AXI4-Lite register front end (upstream) and the compression core (downstream).
- Accepts message words big-endian, byte 0 = [31:24], and counts message length in bits.
- Appends the 0x80 pad byte, zero fill and the 64-bit big-endian bit length.
- Emits a 32-bit word stream grouped into 512-bit (16-word) blocks.

Parameters:
- LEN_W, 64: width of the bit-length accumulator. Values below 64 are zero-extended into the length field.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream word accepted when in_valid && in_ready
- in_data  in  32  message word, big-endian bytes
- in_last  in  1  final word of message
- in_bytes  in  3  valid bytes in the last word, 0..4. Ignored (treated as 4) when !in_last.
- out_valid  out  1  downstream word valid
- out_ready  in  1  downstream accepts
- out_data  out  32  padded stream word
- out_first  out  1  word is index 0 of a block
- out_last  out  1  word is the final length word of the message
- busy  out  1  high from first accepted word until the out_last handshake

Behaviour:
- Output register:
  - out_* is a registered stage; a transfer occurs when out_valid && out_ready.
  - out_data and the flags hold stable while out_valid && !out_ready.
  - The load enable is ld = !out_valid || out_ready.
- in_ready = (state==S_DATA) && ld. It is 0 while ARESETN is low.
- Latency: an accepted word appears on out_data the next cycle.
- Word index and length:
  - nidx (4 bits) = block index of the next loaded word. It increments on every load and wraps 15->0.
  - out_first = (index of the registered word == 0).
  - len += 8*bytes on each accepted word (bytes = 4 unless in_last). Arithmetic is modulo 2^LEN_W.
- States: S_DATA, S_PAD80, S_ZERO, S_LEN_HI, S_LEN_LO.
- S_DATA, accepted non-last word: pass through, stay in S_DATA.
- S_DATA, accepted last word with in_bytes<4:
  - Load the data bytes [0..in_bytes-1], 0x80 at byte in_bytes, zeros after.
  - in_bytes=0 with in_last loads 0x80000000 (empty message).
  - Go to S_ZERO.
- S_DATA, accepted last word with in_bytes==4: load the data unchanged, go to S_PAD80.
- S_PAD80: on ld, load 0x80000000, go to S_ZERO.
- extra flag:
  - Set when the 0x80 word is loaded at nidx 14 or 15.
  - Cleared when nidx wraps to 0.
- S_ZERO: on ld, if nidx==14 && !extra, go to S_LEN_HI without loading. Otherwise load 0x00000000.
- S_LEN_HI: on ld, load len[63:32], go to S_LEN_LO.
- S_LEN_LO: on ld, load len[31:0] with out_last=1, clear len, go to S_DATA.
- The final length word always lands at index 15.
- busy: set on the first accepted word; cleared on the out_last handshake.
- Reset (async, any time including mid-message):
  - state=S_DATA, out_valid=0, out_data=0, out_first=0, out_last=0, busy=0.
  - len=0, nidx=0, extra=0.
  - A partial message is discarded.
- Simultaneous: an out handshake and a new in acceptance in the same cycle is legal (full throughput, one word per cycle).

Optional Feature:
- SHA_PAD_BLOCK_CNT_EN defined:
  - Adds port blk_cnt out 32, counting blocks emitted: increment on each handshake of an index-15 word.
  - Wraps at 2^32; reset 0.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package sha256_pkg holds:
  - WORD_W=32, BLOCK_WORDS=16, PAD_BYTE=8'h80
  - typedef enum pad_state_t {S_DATA,S_PAD80,S_ZERO,S_LEN_HI,S_LEN_LO}
  - function pad_last_word(data, bytes), which returns the masked word with the 0x80 insert
- No sub-module; a single module is natural.

Test Plan:
- "abc": in_data=0x61626300, in_bytes=3, in_last -> 16 words: w0=0x61626380, w1..w14=0, w15=0x00000018; out_first on w0, out_last on w15.
- Empty: in_bytes=0, in_last -> w0=0x80000000, w1..w15=0, out_last on w15.
- 56 bytes, 14 full words, last in_bytes=4 -> 32 words: w14=0x80000000, w15..w30=0, w31=0x000001C0; out_first on w0 and w16.
- 55 bytes: 13 full words plus the last word with in_bytes=3 -> 16 words: w13 = data|0x00000080, w14=0, w15=0x000001B8.
- Backpressure: random in_valid/out_ready over 200 random-length messages vs reference model -> no loss or duplication, out_data stable while stalled.
- Reset mid-message: ARESETN low during S_ZERO -> out_valid=0 and busy=0 immediately; a following "abc" gives w15=0x00000018. With SHA_PAD_BLOCK_CNT_EN, blk_cnt=1.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 padder types and constants: word/block geometry, pad-state encoding
// and the helper that masks a partial final word and inserts the 0x80 pad byte.
package sha256_pkg;

  localparam int         WORD_W      = 32;
  localparam int         BLOCK_WORDS = 16;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN_HI,
    S_LEN_LO
  } pad_state_t;

  // Keep bytes [0..bytes-1] (byte 0 = [31:24]), put 0x80 at byte 'bytes', zero the rest.
  function automatic logic [WORD_W-1:0] pad_last_word(input logic [WORD_W-1:0] data,
                                                      input logic [2:0]        bytes);
    logic [WORD_W-1:0] w;
    case (bytes)
      3'd0:    w = {PAD_BYTE, 24'h000000};
      3'd1:    w = {data[31:24], PAD_BYTE, 16'h0000};
      3'd2:    w = {data[31:16], PAD_BYTE, 8'h00};
      3'd3:    w = {data[31:8], PAD_BYTE};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha256_msg_padder.sv
// Streaming SHA-256 message padder: message words in, padded 16-word blocks out.
// Optional block counter port blk_cnt when SHA_PAD_BLOCK_CNT_EN is defined.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_first,
  output logic              out_last,
`ifdef SHA_PAD_BLOCK_CNT_EN
  output logic [31:0]       blk_cnt,
`endif
  output logic              busy
);

  localparam int               IDX_W      = $clog2(BLOCK_WORDS);
  localparam logic [IDX_W-1:0] IDX_LEN_HI = IDX_W'(BLOCK_WORDS - 2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BLOCK_WORDS - 1);

  pad_state_t        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              extra_q, extra_d;
  logic [IDX_W-1:0]  nidx_q, nidx_d;
  logic [LEN_W-1:0]  len_q, len_d;

  logic              ld;
  logic              in_fire;
  logic              load;
  logic              load_last;
  logic              pad_load;
  logic              skip_zero;
  logic [WORD_W-1:0] load_data;
  logic [2:0]        word_bytes;
  logic [63:0]       len64;

  assign ld         = !out_valid_q || out_ready;
  assign in_ready   = ARESETN && (state_q == S_DATA) && ld;
  assign in_fire    = in_valid && in_ready;
  assign word_bytes = (in_last && (in_bytes < 3'd4)) ? in_bytes : 3'd4;
  assign len64      = 64'(len_q);
  // Zero fill stops two words short of the block end so the length lands at 14/15.
  assign skip_zero  = (nidx_q == IDX_LEN_HI) && !extra_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_DATA;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      extra_q     <= 1'b0;
      nidx_q      <= '0;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      extra_q     <= extra_d;
      nidx_q      <= nidx_d;
      len_q       <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DATA:   if (in_fire && in_last) state_d = (word_bytes == 3'd4) ? S_PAD80 : S_ZERO;
      S_PAD80:  if (ld) state_d = S_ZERO;
      S_ZERO:   if (ld && skip_zero) state_d = S_LEN_HI;
      S_LEN_HI: if (ld) state_d = S_LEN_LO;
      S_LEN_LO: if (ld) state_d = S_DATA;
      default:  state_d = S_DATA;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    load_last = 1'b0;
    pad_load  = 1'b0;
    load_data = '0;
    case (state_q)
      S_DATA: begin
        if (in_fire) begin
          load = 1'b1;
          if (word_bytes != 3'd4) begin
            pad_load  = 1'b1;
            load_data = pad_last_word(in_data, word_bytes);
          end else begin
            load_data = in_data;
          end
        end
      end
      S_PAD80: begin
        load      = ld;
        pad_load  = ld;
        load_data = {PAD_BYTE, 24'h000000};
      end
      S_ZERO:   load = ld && !skip_zero;
      S_LEN_HI: begin
        load      = ld;
        load_data = len64[63:32];
      end
      S_LEN_LO: begin
        load      = ld;
        load_last = 1'b1;
        load_data = len64[31:0];
      end
      default: ;
    endcase

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    nidx_d      = nidx_q;
    extra_d     = extra_q;
    len_d       = len_q;
    busy_d      = busy_q;

    if (ld) out_valid_d = load;
    if (load) begin
      out_data_d  = load_data;
      out_first_d = (nidx_q == '0);
      out_last_d  = load_last;
      nidx_d      = nidx_q + 1'b1;
      // A wrap back to index 0 always wins over setting the flag.
      if (nidx_q == IDX_LAST) extra_d = 1'b0;
      else if (pad_load && (nidx_q == IDX_LEN_HI)) extra_d = 1'b1;
    end

    if (in_fire) len_d = len_q + LEN_W'({word_bytes, 3'b000});
    if ((state_q == S_LEN_LO) && load) len_d = '0;

    if (out_valid_q && out_ready && out_last_q) busy_d = 1'b0;
    if (in_fire) busy_d = 1'b1;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

`ifdef SHA_PAD_BLOCK_CNT_EN
  logic        out_idx_last_q, out_idx_last_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    out_idx_last_d = out_idx_last_q;
    if (load) out_idx_last_d = (nidx_q == IDX_LAST);
    blk_cnt_d = blk_cnt_q;
    if (out_valid_q && out_ready && out_idx_last_q) blk_cnt_d = blk_cnt_q + 32'd1;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_idx_last_q <= 1'b0;
      blk_cnt_q      <= '0;
    end else begin
      out_idx_last_q <= out_idx_last_d;
      blk_cnt_q      <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench for sha256_msg_padder: byte-level padding model, directed
// messages, randomized handshakes and a mid-message reset.
module tb_sha256_msg_padder;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic        out_last;
  logic        busy;
`ifdef SHA_PAD_BLOCK_CNT_EN
  logic [31:0] blk_cnt;
`endif

  sha256_msg_padder #(.LEN_W(64)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
`ifdef SHA_PAD_BLOCK_CNT_EN
    .blk_cnt   (blk_cnt),
`endif
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];
  typedef struct packed {
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[$];
  logic [31:0] cap[$];
  bit          rand_ready = 1'b0;
  bit          rand_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  task automatic abort(input string why);
    errors++;
    checks++;
    $display("FAIL %s", why);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench aborted");
  endtask

  function automatic logic [31:0] cap_at(input int i);
    return (i < cap.size()) ? cap[i] : 32'hxxxxxxxx;
  endfunction

  // Padding from first principles: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit count.
  function automatic word_q_t model_words(input byte_q_t msg);
    byte_q_t     b;
    word_q_t     w;
    logic [63:0] bits;
    b    = msg;
    bits = 64'(msg.size()) * 64'd8;
    b.push_back(8'h80);
    while ((b.size() % 64) != 56) b.push_back(8'h00);
    for (int i = 7; i >= 0; i--) b.push_back(bits[8*i +: 8]);
    for (int i = 0; i < b.size(); i += 4) w.push_back({b[i], b[i+1], b[i+2], b[i+3]});
    return w;
  endfunction

  task automatic push_expected(input byte_q_t msg);
    word_q_t w;
    w = model_words(msg);
    foreach (w[i]) exp_q.push_back('{d: w[i], f: ((i % 16) == 0), l: (i == w.size() - 1)});
  endtask

  // Leaves in_valid asserted after the last word so consecutive calls run back to back.
  task automatic send_msg(input byte_q_t msg);
    int L;
    int nw;
    L  = msg.size();
    nw = (L == 0) ? 1 : (L + 3) / 4;
    push_expected(msg);
    for (int k = 0; k < nw; k++) begin
      logic [31:0] d;
      int          nb;
      int          guard;
      bit          acc;
      nb = (k == nw - 1) ? (L - 4 * k) : 4;
      d  = $urandom();
      for (int j = 0; j < nb; j++) d[31-8*j -: 8] = msg[4*k+j];
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge ACLK);
        in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = d;
        in_last  = (k == nw - 1);
        in_bytes = in_last ? 3'(nb) : 3'($urandom_range(0, 4));
        #1;
        if (in_valid && in_ready) acc = 1'b1;
        guard++;
        if (!acc && guard > 3000) abort("in_ready timeout");
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int g;
    @(negedge ACLK);
    in_valid = 1'b0;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 5000) begin
      @(negedge ACLK);
      #2;
      g++;
    end
    check({name, " drained"}, {exp_q.size(), busy}, 64'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge ACLK);
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: every handshake against the model, and hold-stability while stalled.
  initial begin : monitor
    exp_t        e;
    logic        stall_prev;
    logic [33:0] held;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge ACLK);
      #1;
      if (!ARESETN) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("stall hold", {29'd0, out_valid, out_data, out_first, out_last}, {29'd0, 1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected word", {31'd0, out_valid, out_data}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("out word", {30'd0, out_data, out_first, out_last}, {30'd0, e.d, e.f, e.l});
          end
          cap.push_back(out_data);
        end
        stall_prev = out_valid && !out_ready;
        held       = {out_data, out_first, out_last};
      end
    end
  end

  initial begin
    #900000;
    abort("global timeout");
  end

  initial begin
    byte_q_t abc;
    byte_q_t empty;
    byte_q_t m56;
    byte_q_t m55;
    byte_q_t msg;
    word_q_t w;
    int      g;

    ARESETN  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = '0;
    abc      = '{8'h61, 8'h62, 8'h63};
    for (int i = 0; i < 56; i++) m56.push_back(8'(i + 1));
    for (int i = 0; i < 55; i++) m55.push_back(8'(i + 1));

    repeat (2) @(negedge ACLK);
    #1;
    check("reset out_valid/first/last", {out_valid, out_first, out_last}, 64'd0);
    check("reset out_data", out_data, 64'd0);
    check("reset busy/in_ready", {busy, in_ready}, 64'd0);
`ifdef SHA_PAD_BLOCK_CNT_EN
    check("reset blk_cnt", blk_cnt, 64'd0);
`endif
    ARESETN = 1'b1;

    w = model_words(abc);
    check("model abc size", w.size(), 64'd16);
    check("model abc w0", w[0], 64'h61626380);
    check("model abc w15", w[15], 64'h18);
    w = model_words(empty);
    check("model empty w0", w[0], 64'h80000000);
    w = model_words(m56);
    check("model 56B size", w.size(), 64'd32);
    check("model 56B w31", w[31], 64'h1C0);
    w = model_words(m55);
    check("model 55B w13", w[13], 64'h35363780);
    check("model 55B w15", w[15], 64'h1B8);

    cap.delete();
    send_msg(abc);
    @(negedge ACLK);
    in_valid = 1'b0;
    #1;
    check("abc latency", {29'd0, out_valid, out_first, busy, out_data}, {29'd0, 3'b111, 32'h61626380});
    wait_drain("abc");
    check("abc count", cap.size(), 64'd16);
    check("abc w15", cap_at(15), 64'h18);

    cap.delete();
    send_msg(empty);
    wait_drain("empty");
    check("empty count", cap.size(), 64'd16);
    check("empty w0", cap_at(0), 64'h80000000);
    check("empty w15", cap_at(15), 64'h0);

    cap.delete();
    send_msg(m56);
    wait_drain("56B");
    check("56B count", cap.size(), 64'd32);
    check("56B w14", cap_at(14), 64'h80000000);
    check("56B w31", cap_at(31), 64'h1C0);

    cap.delete();
    send_msg(m55);
    wait_drain("55B");
    check("55B count", cap.size(), 64'd16);
    check("55B w13", cap_at(13), 64'h35363780);
    check("55B w15", cap_at(15), 64'h1B8);

    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      msg.delete();
      for (int i = $urandom_range(0, 140); i > 0; i--) msg.push_back(8'($urandom));
      send_msg(msg);
    end
    wait_drain("random");
    rand_ready = 1'b0;
    rand_valid = 1'b0;

    cap.delete();
    send_msg(abc);
    @(negedge ACLK);
    in_valid = 1'b0;
    g = 0;
    while (cap.size() < 3 && g < 100) begin
      @(negedge ACLK);
      #2;
      g++;
    end
    check("reset setup words", cap.size() >= 3, 64'd1);
    ARESETN = 1'b0;
    #1;
    check("mid reset out_valid/busy/in_ready", {out_valid, busy, in_ready}, 64'd0);
    exp_q.delete();
    @(negedge ACLK);
    ARESETN = 1'b1;
    cap.delete();
    send_msg(abc);
    wait_drain("abc after reset");
    check("abc after reset count", cap.size(), 64'd16);
    check("abc after reset w15", cap_at(15), 64'h18);
`ifdef SHA_PAD_BLOCK_CNT_EN
    check("blk_cnt after reset", blk_cnt, 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
